// File: rtl/pingpong_sequencer.sv
// pingpong_sequencer: write/read controller for a ping-pong sample buffer with swap handshake.
// Define PINGPONG_SEQ_OVF_CNT_EN to build the saturating 16-bit dropped-sample counter.
module pingpong_sequencer #(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic [7:0]  w_addr,
    output logic [31:0] w_data,
    output logic        wren,
    output logic        writeDone,
    output logic [7:0]  r_addr,
    input  logic [31:0] r_q,
    output logic        readDone,
    input  logic        goodToGo,
    input  logic        rd_pause,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic        m_first,
    output logic        m_last,
    output logic        overflow,
    output logic [15:0] ovf_count
);
    typedef enum logic {W_FILL, W_DONE} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} r_state_e;

    localparam logic [7:0] LAST = 8'(DEPTH - 1);

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [7:0]        wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic              filled_q, filled_d, synced_q, synced_d;
    logic              overflow_q, overflow_d;
    logic [RD_LAT-1:0] vld_q, vld_d, first_q, first_d, last_q, last_d, vld_sh;
    logic              swap, drop, issue;

    assign swap   = !goodToGo;
    assign w_data = s_data;
    assign m_data = r_q;
    assign vld_sh = vld_q << 1;

    always_comb begin
        w_state_d = w_state_q;
        wcnt_d    = wcnt_q;
        filled_d  = swap ? 1'b0 : filled_q;
        synced_d  = synced_q | swap;
        wren      = 1'b0;
        w_addr    = 8'd0;
        writeDone = 1'b0;
        drop      = 1'b0;
        if (w_state_q == W_FILL) begin
            wren   = s_valid;
            w_addr = wcnt_q;
            if (s_valid) begin
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_q == LAST) begin
                    w_state_d = W_DONE;
                    filled_d  = 1'b1;
                end
            end
        end else begin
            writeDone = 1'b1;
            drop      = s_valid && synced_q;
            if (swap) begin
                wcnt_d    = 8'd0;
                w_state_d = W_FILL;
            end
        end
        overflow_d = overflow_q | drop;
    end

    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        issue     = 1'b0;
        r_addr    = 8'd0;
        readDone  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                readDone = 1'b1;
                if (swap && filled_q) begin
                    r_state_d = R_READ;
                    rcnt_d    = 8'd0;
                end
            end
            R_READ: begin
                r_addr = rcnt_q;
                issue  = !rd_pause;
                if (issue) begin
                    rcnt_d = rcnt_q + 8'd1;
                    if (rcnt_q == LAST) r_state_d = R_DRAIN;
                end
            end
            // leave once only the word now emerging remains, so readDone follows it by one cycle
            R_DRAIN: r_state_d = (vld_sh == '0) ? R_IDLE : R_DRAIN;
            default: r_state_d = R_IDLE;
        endcase
        vld_d   = vld_sh | RD_LAT'(issue);
        first_d = (first_q << 1) | RD_LAT'(issue && rcnt_q == 8'd0);
        last_d  = (last_q << 1) | RD_LAT'(issue && rcnt_q == LAST);
    end

    assign m_valid  = vld_q[RD_LAT-1];
    assign m_first  = first_q[RD_LAT-1];
    assign m_last   = last_q[RD_LAT-1];
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q  <= W_DONE;
            r_state_q  <= R_IDLE;
            wcnt_q     <= 8'd0;
            rcnt_q     <= 8'd0;
            filled_q   <= 1'b0;
            synced_q   <= 1'b0;
            overflow_q <= 1'b0;
            vld_q      <= '0;
            first_q    <= '0;
            last_q     <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            filled_q   <= filled_d;
            synced_q   <= synced_d;
            overflow_q <= overflow_d;
            vld_q      <= vld_d;
            first_q    <= first_d;
            last_q     <= last_d;
        end
    end

`ifdef PINGPONG_SEQ_OVF_CNT_EN
    logic [15:0] ovf_count_q, ovf_count_d;

    always_comb ovf_count_d = (drop && ovf_count_q != 16'hFFFF) ? ovf_count_q + 16'd1 : ovf_count_q;

    always_ff @(posedge clk) begin
        if (reset) ovf_count_q <= 16'd0;
        else ovf_count_q <= ovf_count_d;
    end

    assign ovf_count = ovf_count_q;
`else
    assign ovf_count = 16'd0;
`endif
endmodule

// File: tb/tb_pingpong_sequencer.sv
// tb_pingpong_sequencer: scoreboard bench with a ping-pong RAM model driving goodToGo and r_q.
module tb_pingpong_sequencer;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;
`ifdef PINGPONG_SEQ_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, s_valid = 1'b0, rd_pause = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic [7:0]  w_addr, r_addr;
    logic [31:0] w_data, r_q, m_data;
    logic        wren, writeDone, readDone, goodToGo, m_valid, m_first, m_last, overflow;
    logic [15:0] ovf_count;

    pingpong_sequencer #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
        .w_addr(w_addr), .w_data(w_data), .wren(wren), .writeDone(writeDone),
        .r_addr(r_addr), .r_q(r_q), .readDone(readDone), .goodToGo(goodToGo),
        .rd_pause(rd_pause), .m_valid(m_valid), .m_data(m_data), .m_first(m_first),
        .m_last(m_last), .overflow(overflow), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Buffer model: two halves, goodToGo low for one cycle after both done, read data delayed RD_LAT cycles.
    logic [31:0] mem [2][DEPTH];
    logic [31:0] rpipe [RD_LAT];
    bit          bank = 1'b0;
    bit          g2g = 1'b1;
    int          cyc = 0;

    assign goodToGo = g2g;
    assign r_q      = rpipe[RD_LAT-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wren) mem[bank][w_addr] <= w_data;
        rpipe[0] <= mem[!bank][r_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (!g2g) bank <= !bank;
        g2g <= !(writeDone && readDone && g2g);
    end

    int          tests = 0, fails = 0;
    logic [33:0] sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int         accept_left = 0, ovf_exp = 0, swaps = 0, since_swap = 0;
    bit         synced = 1'b0, flush = 1'b0, prev_rst = 1'b1, prev_swap = 1'b0, prev_p = 1'b0;
    logic [7:0] last_raddr = 8'd0;

    task automatic step(input logic rst, input logic v, input logic p, input logic [31:0] d);
        bit acc;
        @(posedge clk);
        #1;
        if (flush) begin
            sbq.delete();
            flush = 1'b0;
        end
        reset = rst; s_valid = v; rd_pause = p; s_data = d;
        @(negedge clk);
        acc = v && accept_left > 0;
        if (!rst) begin
            chk("wren", 32'(wren), 32'(acc));
            if (acc) begin
                chk("w_addr", 32'(w_addr), 32'(DEPTH - accept_left));
                chk("w_data", w_data, d);
            end
            chk("overflow", 32'(overflow), 32'(ovf_exp != 0));
            chk("ovf_count", 32'(ovf_count), CNT_EN ? 32'(ovf_exp) : 32'd0);
            if (prev_rst) begin
                chk("rst_writeDone", 32'(writeDone), 32'd1);
                chk("rst_readDone", 32'(readDone), 32'd1);
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_m_first", 32'(m_first), 32'd0);
                chk("rst_m_last", 32'(m_last), 32'd0);
                chk("rst_r_addr", 32'(r_addr), 32'd0);
                chk("rst_w_addr", 32'(w_addr), 32'd0);
            end
            if (!g2g) begin
                chk("swap_writeDone", 32'(writeDone), 32'd1);
                chk("swap_readDone", 32'(readDone), 32'd1);
            end
            if (prev_swap) chk("post_swap_writeDone", 32'(writeDone), 32'd0);
            if (p && prev_p) chk("r_addr_frozen", 32'(r_addr), 32'(last_raddr));
        end
        prev_p     = p && !rst;
        last_raddr = r_addr;
        prev_rst   = rst;
        prev_swap  = !rst && !g2g;
        since_swap++;
        if (rst) begin
            accept_left = 0; synced = 1'b0; ovf_exp = 0; flush = 1'b1; swaps = 0;
        end else begin
            if (acc) begin
                sbq.push_back({accept_left == DEPTH, accept_left == 1, d});
                accept_left--;
            end else if (v && synced) ovf_exp++;
            if (!g2g) begin
                accept_left = DEPTH; synced = 1'b1; swaps++; since_swap = 0;
            end
        end
    endtask

    task automatic wait_swap();
        int n = 0;
        while (accept_left == 0 && n < 50) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            n++;
        end
        if (accept_left == 0) begin
            tests++;
            fails++;
            $display("FAIL swap_timeout: no swap within 50 cycles, required one");
        end
    endtask

    int          swap_cyc = -1000, first_cyc = 0, pcnt = 0;
    bit          in_frame = 1'b0, rd_chk = 1'b0;
    logic [33:0] e;

    always @(negedge clk) begin
        if (rd_chk) begin
            chk("readDone_rise", 32'(readDone), 32'd1);
            rd_chk = 1'b0;
        end
        if (in_frame && rd_pause) pcnt++;
        if (m_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_m_valid: m_data=%0h, required m_valid=0 (cycle %0d)", m_data, cyc);
            end else begin
                e = sbq.pop_front();
                chk("m_data", m_data, e[31:0]);
                chk("m_first", 32'(m_first), 32'(e[33]));
                chk("m_last", 32'(m_last), 32'(e[32]));
                if (m_first) begin
                    chk("first_latency", 32'(cyc - swap_cyc), 32'(1 + RD_LAT));
                    first_cyc = cyc; pcnt = 0; in_frame = 1'b1;
                end
                if (m_last) begin
                    chk("frame_span", 32'(cyc - first_cyc), 32'(DEPTH - 1 + pcnt));
                    chk("readDone_at_last", 32'(readDone), 32'd0);
                    rd_chk = 1'b1; in_frame = 1'b0;
                end
            end
        end
        if (!goodToGo && !reset) swap_cyc = cyc;
    end

    initial begin
        int n;
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
        // continuous samples from reset, with a 10-cycle pause inside the second output frame
        for (int k = 0; k < 800; k++)
            step(1'b0, 1'b1, swaps == 3 && since_swap >= 50 && since_swap < 60, 32'hA000_0000 + 32'(k));
        // writer fills while the reader is held paused, then five samples must be dropped
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0);
        wait_swap();
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 1'b0, 32'hB000_0000 + 32'(k));
        wait_swap();
        for (int k = 0; k < 320; k++)
            step(1'b0, k < DEPTH + 5, k >= 5 && k < 305, 32'hC000_0000 + 32'(k));
        chk("overflow_after_5", 32'(overflow), 32'd1);
        chk("ovf_count_after_5", 32'(ovf_count), CNT_EN ? 32'd5 : 32'd0);
        repeat (700) step(1'b0, 1'b0, 1'b0, 32'd0);
        // reset while writing word 100 and reading the previous frame
        step(1'b1, 1'b0, 1'b0, 32'd0);
        n = 0;
        while (!(swaps == 2 && accept_left == DEPTH - 100) && n < 2000) begin
            step(1'b0, 1'b1, 1'b0, 32'hD000_0000 + 32'(n));
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL mid_frame_setup: writer never reached word 100, required within 2000 cycles");
        end
        step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        for (int k = 0; k < 700; k++) step(1'b0, 1'b1, 1'b0, 32'hE000_0000 + 32'(k));
        repeat (400) step(1'b0, 1'b0, 1'b0, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
